// File: rtl/frame_sequencer.sv
// APU frame sequencer: divides the APU tick into quarter/half-frame clocks
// and raises the frame IRQ, with a delayed restart after each $4017 write.
module frame_sequencer #(
    parameter int WRITE_DELAY = 2
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iApu_tick,
    input  logic       iWrite_4017,
    input  logic [7:0] iData,
    input  logic       iIrq_ack,
    output logic       oQuarter_clk,
    output logic       oHalf_clk,
    output logic       oIrq,
    output logic       oMode
);

    localparam logic [0:0]  ST_RUN     = 1'b0;
    localparam logic [0:0]  ST_PENDING = 1'b1;
    localparam logic [14:0] STEP_1     = 15'd3728;
    localparam logic [14:0] STEP_2     = 15'd7456;
    localparam logic [14:0] STEP_3     = 15'd11185;
    localparam logic [14:0] WRAP_4     = 15'd14914;
    localparam logic [14:0] WRAP_5     = 15'd18640;
    localparam logic [2:0]  DELAY_LOAD = 3'(WRITE_DELAY);

    logic [14:0] cnt;
    logic        mode;
    logic        inhibit;
    logic [2:0]  delay;
    logic [0:0]  state;

    logic [14:0] wrap;
    logic        at_wrap;
    logic        quarter_evt;
    logic        half_evt;
    logic        restart;
    logic        irq_set;

    always_comb begin
        wrap        = mode ? WRAP_5 : WRAP_4;
        // >= also recovers a count left above the wrap by a 5-step to 4-step switch
        at_wrap     = (cnt >= wrap);
        quarter_evt = (cnt == STEP_1) || (cnt == STEP_2) || (cnt == STEP_3) || (cnt == wrap);
        half_evt    = (cnt == STEP_2) || (cnt == wrap);
        restart     = (state == ST_PENDING) && (delay == 3'd1);
        irq_set     = iApu_tick && !iWrite_4017 && !restart && !mode && !inhibit
                      && (cnt == WRAP_4);
    end

    assign oMode = mode;

    always_ff @(posedge clk) begin
        if (iReset) begin
            cnt          <= '0;
            mode         <= 1'b0;
            inhibit      <= 1'b0;
            delay        <= '0;
            state        <= ST_RUN;
            oIrq         <= 1'b0;
            oQuarter_clk <= 1'b0;
            oHalf_clk    <= 1'b0;
        end else begin
            oQuarter_clk <= 1'b0;
            oHalf_clk    <= 1'b0;

            // a set on this edge overrides any simultaneous clear
            if (irq_set)
                oIrq <= 1'b1;
            else if (iIrq_ack || (iWrite_4017 && iData[6]))
                oIrq <= 1'b0;

            if (iWrite_4017) begin
                mode    <= iData[7];
                inhibit <= iData[6];
                delay   <= DELAY_LOAD;
                state   <= ST_PENDING;
            end else if (iApu_tick) begin
                if (restart) begin
                    cnt          <= '0;
                    delay        <= '0;
                    state        <= ST_RUN;
                    oQuarter_clk <= mode;
                    oHalf_clk    <= mode;
                end else begin
                    if (state == ST_PENDING)
                        delay <= delay - 3'd1;
                    cnt          <= at_wrap ? '0 : cnt + 15'd1;
                    oQuarter_clk <= quarter_evt;
                    oHalf_clk    <= half_evt;
                end
            end
        end
    end

endmodule
